// File: rtl/painterengine_gpu_dma_reader.sv
// painterengine_gpu_dma_reader
// Memory-side responder for the display DMA reader port. A word-granular job is split
// into single-outstanding read bursts of at most PARAM_MAX_BURST beats. Returned words
// pass through a small skid buffer and stream out under the consumer's next/valid handshake.
module painterengine_gpu_dma_reader #(
    parameter int PARAM_MAX_BURST  = 16,
    parameter int PARAM_SKID_DEPTH = 2
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_reset,
    input  logic [31:0] i_wire_reader_address,
    input  logic [31:0] i_wire_reader_length,
    input  logic        i_wire_reader_resetn,
    output logic        o_wire_reader_done,
    output logic        o_wire_reader_error,
    output logic [31:0] o_wire_reader_data,
    output logic        o_wire_reader_data_valid,
    input  logic        i_wire_reader_data_next,
    output logic [31:0] o_wire_mem_araddr,
    output logic [7:0]  o_wire_mem_arlen,
    output logic        o_wire_mem_arvalid,
    input  logic        i_wire_mem_arready,
    input  logic [31:0] i_wire_mem_rdata,
    input  logic [1:0]  i_wire_mem_rresp,
    input  logic        i_wire_mem_rlast,
    input  logic        i_wire_mem_rvalid,
    output logic        o_wire_mem_rready
);

    localparam int          PTR_W       = $clog2(PARAM_SKID_DEPTH);
    localparam int          CNT_W       = PTR_W + 1;
    localparam logic [31:0] MAX_BURST_W = 32'(PARAM_MAX_BURST);
    localparam logic [CNT_W-1:0] SKID_FULL_CNT = CNT_W'(PARAM_SKID_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE,
        ST_ERROR,
        ST_DRAIN
    } state_t;

    state_t      state, state_next;
    logic [31:0] cur_addr, cur_addr_next;
    logic [31:0] remaining, remaining_next;
    logic [8:0]  beats_left, beats_left_next;
    logic        drain_err, drain_err_next;
    logic [31:0] burst_beats;

    logic [31:0]      skid_mem [PARAM_SKID_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] skid_count;
    logic             skid_full, skid_empty, skid_push, skid_pop, skid_flush;

    logic r_fire, beat_bad, rready_int;

    // Burst size for the next request: the whole remainder if it fits, else a max burst.
    assign burst_beats = (remaining > MAX_BURST_W) ? MAX_BURST_W : remaining;

    assign skid_full  = (skid_count == SKID_FULL_CNT);
    assign skid_empty = (skid_count == '0);

    // Drain swallows every beat; normal data phase only takes beats the skid can hold.
    assign rready_int = (state == ST_DRAIN) ||
                        ((state == ST_DATA) && (beats_left != 9'd0) && !skid_full);
    assign r_fire     = i_wire_mem_rvalid && rready_int;
    // A bad response or an rlast that disagrees with our beat count both fail the job.
    assign beat_bad   = (i_wire_mem_rresp != 2'd0) || (i_wire_mem_rlast != (beats_left == 9'd1));

    assign o_wire_mem_rready        = rready_int;
    assign o_wire_mem_arvalid       = (state == ST_ADDR);
    assign o_wire_mem_araddr        = (state == ST_ADDR) ? cur_addr : 32'd0;
    assign o_wire_mem_arlen         = (state == ST_ADDR) ? 8'(burst_beats - 32'd1) : 8'd0;
    assign o_wire_reader_done       = (state == ST_DONE);
    assign o_wire_reader_error      = (state == ST_ERROR);
    // Words stream only while a job is live; an aborted or failed job never leaks data.
    assign o_wire_reader_data_valid = !skid_empty && i_wire_reader_data_next &&
                                      ((state == ST_ADDR) || (state == ST_DATA));
    assign o_wire_reader_data       = skid_empty ? 32'd0 : skid_mem[rd_ptr];
    assign skid_pop                 = o_wire_reader_data_valid;

    // Job sequencing: next state, address/length bookkeeping and skid push/flush.
    always_comb begin
        state_next      = state;
        cur_addr_next   = cur_addr;
        remaining_next  = remaining;
        beats_left_next = beats_left;
        drain_err_next  = drain_err;
        skid_push       = 1'b0;
        skid_flush      = 1'b0;
        case (state)
            ST_IDLE: begin
                skid_flush = 1'b1;
                if (i_wire_reader_resetn) begin
                    cur_addr_next  = i_wire_reader_address;
                    remaining_next = i_wire_reader_length;
                    if (i_wire_reader_address[1:0] != 2'd0) begin
                        state_next = ST_ERROR;
                    end else if (i_wire_reader_length == 32'd0) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (i_wire_mem_arready) begin
                    beats_left_next = 9'(burst_beats);
                    cur_addr_next   = cur_addr + (burst_beats << 2);
                    remaining_next  = remaining - burst_beats;
                    drain_err_next  = 1'b0;
                    // Once the request is accepted its beats are owed even on abort.
                    state_next      = i_wire_reader_resetn ? ST_DATA : ST_DRAIN;
                end else if (!i_wire_reader_resetn) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (r_fire) begin
                    beats_left_next = beats_left - 9'd1;
                end
                if (!i_wire_reader_resetn) begin
                    drain_err_next = 1'b0;
                    state_next     = (beats_left_next == 9'd0) ? ST_IDLE : ST_DRAIN;
                end else if (r_fire && beat_bad) begin
                    // If the bus already ended the burst there is nothing left to drain.
                    if (i_wire_mem_rlast || (beats_left == 9'd1)) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next     = ST_DRAIN;
                        drain_err_next = 1'b1;
                    end
                end else if (r_fire) begin
                    skid_push = 1'b1;
                    if ((beats_left == 9'd1) && (remaining != 32'd0)) begin
                        state_next = ST_ADDR;
                    end
                end else if ((beats_left == 9'd0) && skid_empty) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!i_wire_reader_resetn) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERROR: begin
                skid_flush = 1'b1;
                if (!i_wire_reader_resetn) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                skid_flush = 1'b1;
                if (r_fire) begin
                    beats_left_next = beats_left - 9'd1;
                end
                if (beats_left == 9'd0) begin
                    state_next = drain_err ? ST_ERROR : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            state      <= ST_IDLE;
            cur_addr   <= 32'd0;
            remaining  <= 32'd0;
            beats_left <= 9'd0;
            drain_err  <= 1'b0;
        end else begin
            state      <= state_next;
            cur_addr   <= cur_addr_next;
            remaining  <= remaining_next;
            beats_left <= beats_left_next;
            drain_err  <= drain_err_next;
        end
    end

    // Skid pointers and occupancy; flush discards whatever a dead job left behind.
    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset || skid_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            skid_count <= '0;
        end else begin
            if (skid_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (skid_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({skid_push, skid_pop})
                2'b10:   skid_count <= skid_count + 1'b1;
                2'b01:   skid_count <= skid_count - 1'b1;
                default: skid_count <= skid_count;
            endcase
        end
    end

    // Skid storage is pure data; occupancy alone decides what is valid.
    always_ff @(posedge i_wire_clock) begin
        if (skid_push) begin
            skid_mem[wr_ptr] <= i_wire_mem_rdata;
        end
    end

endmodule
